uart_rx: RTL and testbench

//   Serial UART receiver; the receive-side counterpart of the UartTx transmitter.

---
 rtl/uart_rx.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8-bit serial receiver with optional even/odd parity, one or two
// stop bits and a runtime per-bit clock divider. serial_i is synchronized,
// each frame is mid-bit sampled, and the byte is presented with a one-cycle
// valid_o pulse together with parity and framing status.
module uart_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       two_stop_bits_i,
  input  logic       parity_bit_i,
  input  logic       parity_even_i,
  input  logic [7:0] clock_divider_i,
  input  logic       serial_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       parity_error_o,
  output logic       frame_error_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_DONE
  } state_t;

  // Synchronizer chain; the line idles high so the flops reset to 1.
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rx;

  // Frame state and per-frame latched configuration.
  state_t     r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_div;
  logic [7:0] r_shift;
  logic [2:0] r_idx;
  logic       r_armed;
  logic       r_par_en;
  logic       r_par_even;
  logic       r_two_stop;
  logic       r_perr;
  logic       r_ferr;

  // Registered outputs.
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_parity_error;
  logic       r_frame_error;
  logic       r_busy;

  logic [7:0] w_half_m1;
  logic [7:0] w_bit_m1;
  logic       w_start_hit;
  logic       w_bit_hit;

  assign w_rx        = r_sync[SYNC_STAGES-1];
  assign w_half_m1   = {1'b0, r_div[7:1]} - 8'd1;
  assign w_bit_m1    = r_div - 8'd1;
  assign w_start_hit = (r_cnt == w_half_m1);
  assign w_bit_hit   = (r_cnt == w_bit_m1);

  assign data_o         = r_data;
  assign valid_o        = r_valid;
  assign parity_error_o = r_parity_error;
  assign frame_error_o  = r_frame_error;
  assign busy_o         = r_busy;

  // Shift the asynchronous serial line through the metastability flops.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], serial_i};
    end
  end

  // Receive state machine: start detection, mid-bit sampling, delivery.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_div          <= '0;
      r_shift        <= '0;
      r_idx          <= '0;
      r_armed        <= 1'b0;
      r_par_en       <= 1'b0;
      r_par_even     <= 1'b0;
      r_two_stop     <= 1'b0;
      r_perr         <= 1'b0;
      r_ferr         <= 1'b0;
      r_data         <= '0;
      r_valid        <= 1'b0;
      r_parity_error <= 1'b0;
      r_frame_error  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_armed) begin
            r_armed <= w_rx;
          end else if (!w_rx) begin
            r_state    <= S_START;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_armed    <= 1'b0;
            r_div      <= clock_divider_i;
            r_par_en   <= parity_bit_i;
            r_par_even <= parity_even_i;
            r_two_stop <= two_stop_bits_i;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
          end
        end
        S_START: begin
          if (w_start_hit) begin
            r_cnt <= '0;
            if (w_rx) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_DATA;
              r_idx   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DATA: begin
          if (w_bit_hit) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_state <= r_par_en ? S_PARITY : S_STOP1;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_PARITY: begin
          if (w_bit_hit) begin
            r_cnt   <= '0;
            r_perr  <= (^r_shift) ^ w_rx ^ ~r_par_even;
            r_state <= S_STOP1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_STOP1: begin
          if (w_bit_hit) begin
            r_cnt   <= '0;
            r_ferr  <= r_ferr | ~w_rx;
            r_state <= r_two_stop ? S_STOP2 : S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_STOP2: begin
          if (w_bit_hit) begin
            r_cnt   <= '0;
            r_ferr  <= r_ferr | ~w_rx;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_data         <= r_shift;
          r_parity_error <= r_perr;
          r_frame_error  <= r_ferr;
          r_valid        <= 1'b1;
          r_busy         <= 1'b0;
          r_state        <= S_IDLE;
          // Arm from the line level seen during this cycle (still inside the
          // stop bit) so a start edge right after the stop midpoint is caught
          // at div=4; a low stop / break leaves the receiver disarmed.
          r_armed        <= w_rx;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into uart_rx and compares every delivered
// byte, its status flags, busy level and delivery cycle against expectations
// derived from the frame contents and the documented latency.
module tb_uart_rx;

  localparam int SYNC = 2;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       two_stop_bits_i = 1'b0;
  logic       parity_bit_i = 1'b0;
  logic       parity_even_i = 1'b0;
  logic [7:0] clock_divider_i = 8'd16;
  logic       serial_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       parity_error_o;
  logic       frame_error_o;
  logic       busy_o;

  uart_rx #(.SYNC_STAGES(SYNC)) dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .two_stop_bits_i (two_stop_bits_i),
    .parity_bit_i    (parity_bit_i),
    .parity_even_i   (parity_even_i),
    .clock_divider_i (clock_divider_i),
    .serial_i        (serial_i),
    .data_o          (data_o),
    .valid_o         (valid_o),
    .parity_error_o  (parity_error_o),
    .frame_error_o   (frame_error_o),
    .busy_o          (busy_o)
  );

  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       busy;
  } rec_t;

  rec_t got_q[$];
  rec_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Capture every valid pulse.
  always @(negedge clock_i) begin : mon
    rec_t r;
    if (valid_o === 1'b1) begin
      r.cyc  = cyc;
      r.d    = data_o;
      r.pe   = parity_error_o;
      r.fe   = frame_error_o;
      r.busy = busy_o;
      got_q.push_back(r);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one frame and queue its expected delivery.
  task automatic send_frame(input logic [7:0] d, input int div,
                            input bit pen, input bit peven, input bit two,
                            input bit pflip, input bit s1, input bit s2,
                            input bit scr, input logic [7:0] ed,
                            input bit epe, input bit efe);
    logic [11:0] bits;
    int          n;
    rec_t        e;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    n = 9;
    if (pen) begin
      bits[n] = (peven ? ^d : ~^d) ^ pflip;
      n++;
    end
    bits[n] = ~s1;
    n++;
    if (two) begin
      bits[n] = ~s2;
      n++;
    end
    parity_bit_i    = pen;
    parity_even_i   = peven;
    two_stop_bits_i = two;
    clock_divider_i = 8'(div);
    e.cyc  = cyc + SYNC + 1 + div / 2 + div * (n - 1) + 1;
    e.d    = ed;
    e.pe   = epe;
    e.fe   = efe;
    e.busy = 1'b0;
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      serial_i = bits[i];
      repeat (div) @(negedge clock_i);
      if (scr && i == 0) begin
        parity_bit_i    = 1'($urandom_range(0, 1));
        parity_even_i   = 1'($urandom_range(0, 1));
        two_stop_bits_i = 1'($urandom_range(0, 1));
        clock_divider_i = 8'($urandom);
      end
    end
  endtask

  // Wait (bounded) for all queued deliveries, then compare them in order.
  task automatic check_all(input string tag);
    int w;
    int m;
    w = 0;
    while (got_q.size() < exp_q.size() && w < 20000) begin
      @(negedge clock_i);
      #1;
      w++;
    end
    repeat (3) @(negedge clock_i);
    #1;
    chk($sformatf("%s.count", tag), got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s[%0d].cycle", tag, i), got_q[i].cyc, exp_q[i].cyc);
      chk($sformatf("%s[%0d].data", tag, i), {24'd0, got_q[i].d}, {24'd0, exp_q[i].d});
      chk($sformatf("%s[%0d].perr", tag, i), {31'd0, got_q[i].pe}, {31'd0, exp_q[i].pe});
      chk($sformatf("%s[%0d].ferr", tag, i), {31'd0, got_q[i].fe}, {31'd0, exp_q[i].fe});
      chk($sformatf("%s[%0d].busy", tag, i), {31'd0, got_q[i].busy}, {31'd0, exp_q[i].busy});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic [7:0] d;
    int         div;
    bit         pen;
    bit         peven;
    bit         two;
    bit         pflip;
    bit         s1;
    bit         s2;
    logic [7:0] ed;
    bit         epe;
    bit         efe;
  } vec_t;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t       vt[7];
    logic [7:0] rd;
    int         rdiv;
    bit         pen, peven, two, pflip, s1, s2, last_low;

    vt[0] = '{8'h55, 217, 0, 0, 0, 0, 0, 0, 8'h55, 0, 0};
    vt[1] = '{8'hA5, 16,  1, 1, 0, 0, 0, 0, 8'hA5, 0, 0};
    vt[2] = '{8'hA5, 16,  1, 1, 0, 1, 0, 0, 8'hA5, 1, 0};
    vt[3] = '{8'h3C, 16,  1, 0, 0, 0, 0, 0, 8'h3C, 0, 0};
    vt[4] = '{8'h81, 4,   0, 0, 1, 0, 0, 0, 8'h81, 0, 0};
    vt[5] = '{8'h7E, 16,  0, 0, 0, 0, 1, 0, 8'h7E, 0, 1};
    vt[6] = '{8'hF0, 9,   1, 0, 1, 1, 0, 1, 8'hF0, 1, 1};

    // Reset state.
    repeat (2) @(negedge clock_i);
    #1;
    chk("reset.data", {24'd0, data_o}, 32'd0);
    chk("reset.valid", {31'd0, valid_o}, 32'd0);
    chk("reset.perr", {31'd0, parity_error_o}, 32'd0);
    chk("reset.ferr", {31'd0, frame_error_o}, 32'd0);
    chk("reset.busy", {31'd0, busy_o}, 32'd0);
    @(negedge clock_i);
    reset_i = 1'b0;
    repeat (4) @(negedge clock_i);

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      send_frame(vt[i].d, vt[i].div, vt[i].pen, vt[i].peven, vt[i].two,
                 vt[i].pflip, vt[i].s1, vt[i].s2, 1'b0,
                 vt[i].ed, vt[i].epe, vt[i].efe);
      serial_i = 1'b1;
      repeat (20) @(negedge clock_i);
      check_all($sformatf("vec%0d", i));
    end

    // Back-to-back frames with zero idle gap.
    send_frame(8'h01, 16, 0, 0, 0, 0, 0, 0, 0, 8'h01, 0, 0);
    send_frame(8'hFE, 16, 0, 0, 0, 0, 0, 0, 0, 8'hFE, 0, 0);
    serial_i = 1'b1;
    check_all("b2b");

    // Low second stop bit, then the line held low: exactly one delivery.
    send_frame(8'h5A, 16, 0, 0, 1, 0, 0, 1, 0, 8'h5A, 0, 1);
    repeat (100) @(negedge clock_i);
    check_all("break");
    serial_i = 1'b1;
    repeat (5) @(negedge clock_i);
    send_frame(8'hC3, 16, 0, 0, 0, 0, 0, 0, 0, 8'hC3, 0, 0);
    serial_i = 1'b1;
    repeat (10) @(negedge clock_i);
    check_all("after_break");

    // False start: 5 low cycles then high.
    @(negedge clock_i);
    clock_divider_i = 8'd16;
    serial_i = 1'b0;
    repeat (5) @(negedge clock_i);
    serial_i = 1'b1;
    #1;
    chk("false.busy_high", {31'd0, busy_o}, 32'd1);
    repeat (30) @(negedge clock_i);
    #1;
    chk("false.busy_low", {31'd0, busy_o}, 32'd0);
    chk("false.data", {24'd0, data_o}, 32'h0000_00C3);
    chk("false.no_valid", got_q.size(), 32'd0);

    // Reset in the middle of data bit 4.
    @(negedge clock_i);
    clock_divider_i = 8'd16;
    parity_bit_i    = 1'b0;
    two_stop_bits_i = 1'b0;
    serial_i = 1'b0;
    repeat (16) @(negedge clock_i);
    rd = 8'h3C;
    for (int b = 0; b < 4; b++) begin
      serial_i = rd[b];
      repeat (16) @(negedge clock_i);
    end
    serial_i = rd[4];
    repeat (8) @(negedge clock_i);
    chk("midreset.busy_before", {31'd0, busy_o}, 32'd1);
    reset_i = 1'b1;
    #1;
    chk("midreset.data", {24'd0, data_o}, 32'd0);
    chk("midreset.valid", {31'd0, valid_o}, 32'd0);
    chk("midreset.perr", {31'd0, parity_error_o}, 32'd0);
    chk("midreset.ferr", {31'd0, frame_error_o}, 32'd0);
    chk("midreset.busy", {31'd0, busy_o}, 32'd0);
    serial_i = 1'b1;
    @(negedge clock_i);
    reset_i = 1'b0;
    repeat (40) @(negedge clock_i);
    chk("midreset.no_valid", got_q.size(), 32'd0);
    send_frame(8'h3C, 16, 0, 0, 0, 0, 0, 0, 0, 8'h3C, 0, 0);
    serial_i = 1'b1;
    check_all("after_reset");

    // Randomized frames in batches, including zero-gap sequences.
    for (int batch = 0; batch < 5; batch++) begin
      for (int k = 0; k < 8; k++) begin
        rd    = 8'($urandom);
        rdiv  = $urandom_range(4, 24);
        pen   = 1'($urandom_range(0, 1));
        peven = 1'($urandom_range(0, 1));
        two   = 1'($urandom_range(0, 1));
        pflip = pen & 1'($urandom_range(0, 1));
        s1    = ($urandom_range(0, 3) == 0);
        s2    = ($urandom_range(0, 3) == 0);
        last_low = two ? s2 : s1;
        send_frame(rd, rdiv, pen, peven, two, pflip, s1, s2, 1'b1,
                   rd, pen & pflip, s1 | (two & s2));
        serial_i = 1'b1;
        if (last_low) repeat ($urandom_range(2, 10)) @(negedge clock_i);
        else repeat ($urandom_range(0, 6)) @(negedge clock_i);
      end
      serial_i = 1'b1;
      check_all($sformatf("rand%0d", batch));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
